// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: receive parser state encoding, header constants
// and the header byte counter helper.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        READ_HEADER  = 2'd1,
        READ_PAYLOAD = 2'd2,
        DROP         = 2'd3
    } eth_rx_state_t;

    localparam int unsigned ETH_HDR_LEN   = 14;
    localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [3:0]  ETH_HDR_LAST  = 4'(ETH_HDR_LEN - 1);

    // Header byte counter stops at the header length so it never wraps.
    function automatic logic [3:0] hdr_cnt_inc(input logic [3:0] cnt);
        return (cnt >= 4'(ETH_HDR_LEN)) ? 4'(ETH_HDR_LEN) : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/axis_skid8.sv
// Two-entry skid buffer for an 8-bit stream with tlast/tuser sideband.
// Input ready is registered; accepted bytes appear on the output one cycle later.
module axis_skid8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       s_tlast,
    input  logic       s_tuser,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic       m_tlast,
    output logic       m_tuser
);

    logic [9:0] out_reg, out_next;
    logic [9:0] skid_reg, skid_next;
    logic       out_valid_reg, out_valid_next;
    logic       skid_valid_reg, skid_valid_next;
    logic       ready_reg;
    logic       s_accept;
    logic       out_free;

    assign s_accept = s_tvalid && ready_reg;
    assign out_free = !out_valid_reg || m_tready;

    // Ready tracks "skid empty", so an accept never coincides with a full skid.
    always_comb begin
        out_next        = out_reg;
        out_valid_next  = out_valid_reg;
        skid_next       = skid_reg;
        skid_valid_next = skid_valid_reg;
        if (out_free) begin
            if (skid_valid_reg) begin
                out_next        = skid_reg;
                out_valid_next  = 1'b1;
                skid_valid_next = 1'b0;
            end else if (s_accept) begin
                out_next       = {s_tuser, s_tlast, s_tdata};
                out_valid_next = 1'b1;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (s_accept) begin
            skid_next       = {s_tuser, s_tlast, s_tdata};
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg        <= '0;
            skid_reg       <= '0;
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            ready_reg      <= 1'b0;
        end else begin
            out_reg        <= out_next;
            skid_reg       <= skid_next;
            out_valid_reg  <= out_valid_next;
            skid_valid_reg <= skid_valid_next;
            ready_reg      <= !skid_valid_next;
        end
    end

    assign s_tready = ready_reg;
    assign m_tdata  = out_reg[7:0];
    assign m_tlast  = out_reg[8];
    assign m_tuser  = out_reg[9];
    assign m_tvalid = out_valid_reg;

endmodule

// File: rtl/eth_frame_rx.sv
// Ethernet frame receiver: splits a raw MAC byte stream into a header handshake
// and a payload stream. Optional destination filter: ETH_FRAME_RX_DEST_FILTER_EN.
module eth_frame_rx
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        m_eth_hdr_valid,
    input  logic        m_eth_hdr_ready,
    output logic [47:0] m_eth_dest_mac,
    output logic [47:0] m_eth_src_mac,
    output logic [15:0] m_eth_type,
    output logic [7:0]  m_eth_payload_axis_tdata,
    output logic        m_eth_payload_axis_tvalid,
    input  logic        m_eth_payload_axis_tready,
    output logic        m_eth_payload_axis_tlast,
    output logic        m_eth_payload_axis_tuser,
    output logic        busy,
    output logic        error_header_early_termination,
    output logic        drop_filtered,
    input  logic [47:0] local_mac
);

    eth_rx_state_t state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic [47:0]   dest_reg, dest_next;
    logic [47:0]   src_reg, src_next;
    logic [15:0]   eth_type_reg, eth_type_next;
    logic          hdr_valid_reg, hdr_valid_next;
    logic          err_reg, err_next;
    logic          drop_reg, drop_next;
    logic          run_reg;
    logic          in_accept;
    logic          tready_mux;
    logic          skid_s_valid;
    logic          skid_s_ready;
    logic          filter_reject;

`ifdef ETH_FRAME_RX_DEST_FILTER_EN
    logic [47:0] dest_cand;
    logic [5:0]  byte_local;
    logic [5:0]  byte_bcast;

    assign dest_cand = {dest_reg[39:0], s_axis_tdata};

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_filt
            assign byte_local[gi] = (dest_cand[8*gi +: 8] == local_mac[8*gi +: 8]);
            assign byte_bcast[gi] = (dest_cand[8*gi +: 8] == ETH_BCAST_MAC[8*gi +: 8]);
        end
    endgenerate

    assign filter_reject = !(&byte_local) && !(&byte_bcast);
`else
    logic unused_local_mac;
    assign unused_local_mac = ^local_mac;
    assign filter_reject    = 1'b0;
`endif

    assign in_accept = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            dest_reg      <= '0;
            src_reg       <= '0;
            eth_type_reg  <= '0;
            hdr_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            drop_reg      <= 1'b0;
            run_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            dest_reg      <= dest_next;
            src_reg       <= src_next;
            eth_type_reg  <= eth_type_next;
            hdr_valid_reg <= hdr_valid_next;
            err_reg       <= err_next;
            drop_reg      <= drop_next;
            run_reg       <= 1'b1;
        end
    end

    // Header bytes are only accepted while no header is pending, so the
    // field registers stay frozen for the whole header handshake.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        dest_next      = dest_reg;
        src_next       = src_reg;
        eth_type_next  = eth_type_reg;
        hdr_valid_next = hdr_valid_reg && !m_eth_hdr_ready;
        err_next       = 1'b0;
        drop_next      = 1'b0;
        case (state_reg)
            IDLE, READ_HEADER: begin
                if (in_accept) begin
                    if (cnt_reg < 4'd6) begin
                        dest_next = {dest_reg[39:0], s_axis_tdata};
                    end else if (cnt_reg < 4'd12) begin
                        src_next = {src_reg[39:0], s_axis_tdata};
                    end else begin
                        eth_type_next = {eth_type_reg[7:0], s_axis_tdata};
                    end
                    if (s_axis_tlast) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt_reg == ETH_HDR_LAST) begin
                        hdr_valid_next = 1'b1;
                        state_next     = READ_PAYLOAD;
                        cnt_next       = hdr_cnt_inc(cnt_reg);
                    end else if (cnt_reg == 4'd5 && filter_reject) begin
                        drop_next  = 1'b1;
                        state_next = DROP;
                        cnt_next   = hdr_cnt_inc(cnt_reg);
                    end else begin
                        state_next = READ_HEADER;
                        cnt_next   = hdr_cnt_inc(cnt_reg);
                    end
                end
            end
            READ_PAYLOAD, DROP: begin
                if (in_accept && s_axis_tlast) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tready_mux   = 1'b0;
        skid_s_valid = 1'b0;
        case (state_reg)
            IDLE, READ_HEADER: tready_mux = !hdr_valid_reg;
            READ_PAYLOAD: begin
                tready_mux   = skid_s_ready;
                skid_s_valid = s_axis_tvalid;
            end
            DROP:    tready_mux = 1'b1;
            default: tready_mux = 1'b0;
        endcase
        s_axis_tready = run_reg && tready_mux;
        busy          = (state_reg != IDLE);
    end

    axis_skid8 u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (s_axis_tdata),
        .s_tvalid (skid_s_valid),
        .s_tready (skid_s_ready),
        .s_tlast  (s_axis_tlast),
        .s_tuser  (s_axis_tuser),
        .m_tdata  (m_eth_payload_axis_tdata),
        .m_tvalid (m_eth_payload_axis_tvalid),
        .m_tready (m_eth_payload_axis_tready),
        .m_tlast  (m_eth_payload_axis_tlast),
        .m_tuser  (m_eth_payload_axis_tuser)
    );

    assign m_eth_hdr_valid                = hdr_valid_reg;
    assign m_eth_dest_mac                 = dest_reg;
    assign m_eth_src_mac                  = src_reg;
    assign m_eth_type                     = eth_type_reg;
    assign error_header_early_termination = err_reg;
    assign drop_filtered                  = drop_reg;

endmodule
